// File: rtl/aes_resp_buffer.sv
// Response buffer behind the AES core: show-ahead byte FIFO plus a single-entry ack slot,
// drained by a slow host through synchronised, edge-detected pad strobes.
module aes_resp_buffer #(
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    aes_data,
  input  logic          aes_data_valid,
  output logic          aes_data_ready,
  input  logic          aes_ack_valid,
  output logic          aes_ack_ready,
  input  logic [1:0]    aes_source_id,
  input  logic          pop_pin,
  input  logic          ack_clr_pin,
  input  logic          flush,
  output logic [7:0]    out_byte,
  output logic          out_valid,
  output logic          ack_pending,
  output logic [1:0]    ack_id,
  output logic [AW:0]   count,
  output logic          underflow
);

  localparam logic [AW:0] DepthW = (AW+1)'(DEPTH);

  typedef enum logic {AckEmpty, AckFull} ack_state_e;

  // Pad strobes: 2-flop synchroniser followed by a rising-edge detector.
  logic [1:0] pop_sync_q, clr_sync_q;
  logic       pop_prev_q, clr_prev_q;
  logic       pop_req, clr_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pop_sync_q <= 2'b00;
      clr_sync_q <= 2'b00;
      pop_prev_q <= 1'b0;
      clr_prev_q <= 1'b0;
    end else begin
      pop_sync_q <= {pop_sync_q[0], pop_pin};
      clr_sync_q <= {clr_sync_q[0], ack_clr_pin};
      pop_prev_q <= pop_sync_q[1];
      clr_prev_q <= clr_sync_q[1];
    end
  end

  assign pop_req = pop_sync_q[1] & ~pop_prev_q;
  assign clr_req = clr_sync_q[1] & ~clr_prev_q;

  // FIFO; pointers carry an extra wrap bit so occupancy is a plain difference.
  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_next;
  logic        ready_q, ready_d;
  logic        underflow_q, underflow_d;
  logic        push, pop;

  assign count     = wr_ptr_q - rd_ptr_q;
  assign out_valid = (count != '0);
  assign out_byte  = out_valid ? mem[rd_ptr_q[AW-1:0]] : 8'h00;
  assign push      = aes_data_valid && ready_q;
  assign pop       = pop_req && out_valid;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    underflow_d = underflow_q;
    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      underflow_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      if (pop_req && !out_valid) underflow_d = 1'b1;
    end
    count_next = wr_ptr_d - rd_ptr_d;
    ready_d    = (count_next < DepthW);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ready_q     <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ready_q     <= ready_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage needs no reset: out_byte is masked while empty.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr_q[AW-1:0]] <= aes_data;
  end

  assign aes_data_ready = ready_q;
  assign underflow      = underflow_q;

  // Ack slot
  ack_state_e ack_state_q, ack_state_d;
  logic [1:0] ack_id_q, ack_id_d;

  always_comb begin
    ack_state_d = ack_state_q;
    ack_id_d    = ack_id_q;
    unique case (ack_state_q)
      AckEmpty: begin
        if (aes_ack_valid) begin
          ack_state_d = AckFull;
          ack_id_d    = aes_source_id;
        end
      end
      AckFull: begin
        if (clr_req) ack_state_d = AckEmpty;
      end
      default: ack_state_d = AckEmpty;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_state_q <= AckEmpty;
      ack_id_q    <= 2'b00;
    end else begin
      ack_state_q <= ack_state_d;
      ack_id_q    <= ack_id_d;
    end
  end

  assign ack_pending   = (ack_state_q == AckFull);
  assign ack_id        = ack_id_q;
  assign aes_ack_ready = !ack_pending && !rst;

endmodule

// File: tb/tb_aes_resp_buffer.sv
// Scoreboard bench for aes_resp_buffer: accepted bytes are queued, a monitor checks every pop.
module tb_aes_resp_buffer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] aes_data = 8'h00;
  logic       aes_data_valid = 1'b0;
  logic       aes_data_ready;
  logic       aes_ack_valid = 1'b0;
  logic       aes_ack_ready;
  logic [1:0] aes_source_id = 2'b00;
  logic       pop_pin = 1'b0;
  logic       ack_clr_pin = 1'b0;
  logic       flush = 1'b0;
  logic [7:0] out_byte;
  logic       out_valid;
  logic       ack_pending;
  logic [1:0] ack_id;
  logic [4:0] count;
  logic       underflow;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  aes_resp_buffer #(.DEPTH(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .aes_data       (aes_data),
    .aes_data_valid (aes_data_valid),
    .aes_data_ready (aes_data_ready),
    .aes_ack_valid  (aes_ack_valid),
    .aes_ack_ready  (aes_ack_ready),
    .aes_source_id  (aes_source_id),
    .pop_pin        (pop_pin),
    .ack_clr_pin    (ack_clr_pin),
    .flush          (flush),
    .out_byte       (out_byte),
    .out_valid      (out_valid),
    .ack_pending    (ack_pending),
    .ack_id         (ack_id),
    .count          (count),
    .underflow      (underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pre-edge sample, then infer push/pop from the occupancy change.
  int         s_cnt;
  logic [7:0] s_ob, s_data, e_byte;
  logic       s_push, s_fl, s_rst;

  always @(posedge clk) begin
    s_cnt  = int'(count);
    s_ob   = out_byte;
    s_push = aes_data_valid && aes_data_ready;
    s_data = aes_data;
    s_fl   = flush;
    s_rst  = rst;
    #1;
    if (s_rst || rst || s_fl) begin
      exp_q.delete();
    end else begin
      if (int'(count) == s_cnt + int'(s_push) - 1) begin
        if (exp_q.size() == 0) begin
          check("pop_with_empty_scoreboard", 1, 0);
        end else begin
          e_byte = exp_q.pop_front();
          check("pop_byte", int'(s_ob), int'(e_byte));
        end
      end
      if (s_push) exp_q.push_back(s_data);
      check("mon_count", int'(count), exp_q.size());
    end
  end

  task automatic push_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    aes_data = b;
    aes_data_valid = 1'b1;
    while (!aes_data_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("push_timeout", 1, 0);
    @(negedge clk);
    aes_data_valid = 1'b0;
  endtask

  task automatic pin_pulse(input bit is_clr);
    @(negedge clk);
    if (is_clr) ack_clr_pin = 1'b1; else pop_pin = 1'b1;
    repeat (2) @(negedge clk);
    ack_clr_pin = 1'b0;
    pop_pin = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst = 1'b1;
    @(negedge clk);
    check("rst_ready", int'(aes_data_ready), 0);
    check("rst_ack_ready", int'(aes_ack_ready), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_byte", int'(out_byte), 0);
    check("rst_count", int'(count), 0);
    rst = 1'b0;
    #1 check("ready_before_edge", int'(aes_data_ready), 0);
    @(negedge clk);
    check("ready_after_release", int'(aes_data_ready), 1);

    // Fill and backpressure
    for (int i = 0; i < 16; i++) begin
      aes_data = 8'(i);
      aes_data_valid = 1'b1;
      @(negedge clk);
    end
    aes_data = 8'hAA;
    check("full_count", int'(count), 16);
    check("full_ready", int'(aes_data_ready), 0);
    repeat (3) @(negedge clk);
    check("full_hold_count", int'(count), 16);
    pop_pin = 1'b1;
    repeat (2) @(negedge clk);
    pop_pin = 1'b0;
    @(negedge clk);
    check("full_pop_ready", int'(aes_data_ready), 1);
    check("full_pop_count", int'(count), 15);
    @(negedge clk);
    check("refill_count", int'(count), 16);
    check("refill_ready", int'(aes_data_ready), 0);
    aes_data_valid = 1'b0;
    for (int i = 0; i < 16; i++) pin_pulse(1'b0);
    check("drain_count", int'(count), 0);
    check("drain_out_valid", int'(out_valid), 0);
    check("drain_out_byte", int'(out_byte), 0);

    // Ordering across pointer wrap
    for (int i = 0; i < 20; i++) begin
      push_byte(8'h10 + 8'(i));
      pin_pulse(1'b0);
    end
    check("order_count", int'(count), 0);
    check("order_underflow", int'(underflow), 0);

    // Held pin produces one pop, three edges after the rise
    push_byte(8'h30);
    push_byte(8'h31);
    @(negedge clk);
    check("pin_head", int'(out_byte), 8'h30);
    pop_pin = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c < 3) check("pin_before_pop", int'(count), 2);
      else check("pin_single_pop", int'(count), 1);
      if (c == 3) check("pin_next_byte", int'(out_byte), 8'h31);
    end
    pop_pin = 1'b0;
    repeat (3) @(negedge clk);
    pin_pulse(1'b0);
    check("pin_empty", int'(count), 0);

    // Underflow and flush
    pin_pulse(1'b0);
    check("underflow_set", int'(underflow), 1);
    check("underflow_count", int'(count), 0);
    push_byte(8'h41);
    push_byte(8'h42);
    push_byte(8'h43);
    @(negedge clk);
    check("preflush_count", int'(count), 3);
    check("preflush_underflow", int'(underflow), 1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_count", int'(count), 0);
    check("flush_underflow", int'(underflow), 0);
    check("flush_out_valid", int'(out_valid), 0);

    // Ack slot
    check("ack_idle_ready", int'(aes_ack_ready), 1);
    aes_source_id = 2'b10;
    aes_ack_valid = 1'b1;
    @(negedge clk);
    check("ack_pending", int'(ack_pending), 1);
    check("ack_id_first", int'(ack_id), 2);
    check("ack_ready_busy", int'(aes_ack_ready), 0);
    aes_source_id = 2'b01;
    repeat (2) @(negedge clk);
    check("ack_held_id", int'(ack_id), 2);
    ack_clr_pin = 1'b1;
    repeat (2) @(negedge clk);
    ack_clr_pin = 1'b0;
    @(negedge clk);
    check("ack_cleared", int'(ack_pending), 0);
    check("ack_ready_free", int'(aes_ack_ready), 1);
    check("ack_id_retained", int'(ack_id), 2);
    @(negedge clk);
    check("ack_second", int'(ack_pending), 1);
    check("ack_id_second", int'(ack_id), 1);
    aes_ack_valid = 1'b0;

    // Reset mid-traffic with data buffered and ack pending
    for (int i = 0; i < 5; i++) push_byte(8'h50 + 8'(i));
    @(negedge clk);
    check("prerst_count", int'(count), 5);
    rst = 1'b1;
    #1;
    check("midrst_count", int'(count), 0);
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_ack_pending", int'(ack_pending), 0);
    check("midrst_ready", int'(aes_data_ready), 0);
    @(negedge clk);
    check("midrst_ready_hold", int'(aes_data_ready), 0);
    rst = 1'b0;
    @(negedge clk);
    check("postrst_ready", int'(aes_data_ready), 1);
    check("postrst_count", int'(count), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aes_resp_buffer.md
Name: aes_resp_buffer

Overview:
- Stage directly downstream of the `aes` core in the TinyTapeout wrapper.
- Consumes the core's byte-wide result stream (`data_out`/`data_valid`/`data_ready`) into a show-ahead FIFO.
- Consumes the core's completion handshake (`ack_valid`/`ack_ready` plus `module_source_id`) into a single-entry ack slot.
- Lets a slow off-chip host drain results through pad-level strobes, which are synchronised and edge-detected.

Parameters:
- DEPTH, 16, FIFO entries; power of two, ≥ 2.
- AW, $clog2(DEPTH), pointer width; derived, not overridable.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  reset, asynchronous, active-high.
- aes_data  in  8  result byte from the core.
- aes_data_valid  in  1  result byte valid.
- aes_data_ready  out  1  buffer accepts a byte (registered).
- aes_ack_valid  in  1  core signals operation complete.
- aes_ack_ready  out  1  ack slot free.
- aes_source_id  in  2  source ID qualifying `aes_ack_valid`.
- pop_pin  in  1  asynchronous pad strobe; each rising edge consumes one byte.
- ack_clr_pin  in  1  asynchronous pad strobe; each rising edge clears the ack slot.
- flush  in  1  synchronous FIFO flush, level, internal.
- out_byte  out  8  FIFO head byte.
- out_valid  out  1  FIFO non-empty.
- ack_pending  out  1  ack slot occupied.
- ack_id  out  2  source ID captured in the ack slot.
- count  out  AW+1  current FIFO occupancy.
- underflow  out  1  sticky: pop seen while FIFO empty.

Behaviour:
- Reset (rst high, async) clears the following:
  - pointers, `count`, `ack_pending`, `ack_id`, `underflow`;
  - both synchroniser chains and edge registers;
  - outputs during reset: `aes_data_ready`=0, `aes_ack_ready`=0, `out_valid`=0, `out_byte`=8'h00.
- `aes_data_ready` rises on the first clk edge after rst deasserts.
- Reset mid-transfer discards all buffered data and any pending ack.
- Pad inputs:
  - each pad input passes through a 2-flop synchroniser, then a rising-edge detector, producing a 1-cycle pulse (`pop_req`, `clr_req`);
  - pin rise to internal pulse latency is 3 clk edges;
  - a level held high produces exactly one pulse.
- Push: occurs when `aes_data_valid && aes_data_ready` at a clk edge. Writes `aes_data` at `wr_ptr`; `wr_ptr` wraps modulo DEPTH.
- `aes_data_ready` is registered:
  - next value = (`count_next` < DEPTH);
  - deasserts in the same edge that takes the buffer full; never overflows.
- Pop: occurs when `pop_req && out_valid`. Advances `rd_ptr`, wrapping modulo DEPTH.
- `pop_req` with the FIFO empty is ignored and sets `underflow`. `underflow` clears only on rst or `flush`.
- Show-ahead output:
  - `out_byte` = mem[`rd_ptr`] whenever `out_valid`, else 8'h00;
  - after a pop, the next byte is visible on the following cycle;
  - a byte pushed into an empty FIFO is visible with `out_valid`=1 one cycle after the push edge.
- Simultaneous push and pop (non-empty, not full): both occur and `count` is unchanged.
- Full case: `ready`=0, so only the pop occurs. `ready` returns to 1 the next cycle.
- Empty case: push occurs, pop is treated as underflow.
- Flush: while `flush`=1, pointers, `count` and `underflow` reset every cycle.
  - A concurrent handshake completes (ready is as registered) but its byte is discarded.
  - Flush does not affect the ack slot.
- Ack slot (2 states):
  - EMPTY: `aes_ack_ready`=1. On `aes_ack_valid` → FULL, capture `ack_id`=`aes_source_id`, set `ack_pending`=1.
  - FULL: `aes_ack_ready`=0; `aes_ack_valid` is held off. On `clr_req` → EMPTY; `ack_id` is retained until the next capture.
  - `clr_req` in EMPTY has no effect.
  - `aes_ack_ready` is combinational, = !`ack_pending` && !rst.
- Ack and data are independent: an ack may be captured while bytes remain in the FIFO.
- `count` = `wr_ptr` − `rd_ptr` using an extra MSB wrap bit on each pointer; full when MSBs differ and the low bits are equal.

Test Plan:
- Reset/idle: assert rst mid-sim with 5 bytes buffered and an ack pending → `count`=0, `out_valid`=0, `ack_pending`=0, `aes_data_ready`=0 during rst and 1 one cycle after release.
- Fill/backpressure: push 8'h00..8'h0F continuously → `count`=16, `aes_data_ready`=0 after the 16th push; a 17th byte 8'hAA held valid is not written. Pop once → `ready`=1 next cycle, 8'hAA is accepted, `count`=16.
- Order/wrap: push 20 bytes 8'h10..8'h23 interleaved with 20 pop_pin pulses → `out_byte` sequence matches exactly across pointer wrap; final `count`=0, `underflow`=0.
- Pin sync: raise pop_pin for 10 cycles with 2 bytes buffered → exactly one pop, 3 cycles after the rise; `out_byte` advances to the 2nd byte.
- Underflow/flush: pop_pin pulse on empty → `underflow`=1. Then push 3 bytes, flush 1 cycle → `count`=0, `underflow`=0.
- Ack: `aes_ack_valid` with id 2'b10 → `ack_pending`=1, `ack_id`=2'b10, `aes_ack_ready`=0. A second ack (id 2'b01) is held; after an ack_clr_pin pulse (+3 cycles) the slot empties, then captures 2'b01 the next cycle.
